// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider: divided clock plus a one-cycle tick per period.
// New period/high-time values take effect only at a period boundary.
// Optional build macro PROG_CLKDIV_PERIOD_COUNT_EN adds the period_count output.
module prog_clock_divider #(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_DIV  = 20,
    parameter int DEFAULT_HIGH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] div_value,
    input  logic [CNT_W-1:0] high_value,
    output logic             divided_clk,
    output logic             tick,
`ifdef PROG_CLKDIV_PERIOD_COUNT_EN
    output logic             pending,
    output logic [15:0]      period_count
`else
    output logic             pending
`endif
);

    logic [CNT_W-1:0] cnt;
    logic             running;
    logic [CNT_W-1:0] n_act;
    logic [CNT_W-1:0] h_act;
    logic [CNT_W-1:0] shadow_n;
    logic [CNT_W-1:0] shadow_h;

    logic             boundary;
    logic [CNT_W-1:0] n_next;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] next_cnt;

    function automatic logic [CNT_W-1:0] clamp_n(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(2)) ? CNT_W'(2) : v;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_h(input logic [CNT_W-1:0] h,
                                                 input logic [CNT_W-1:0] n);
        return (h > n) ? n : h;
    endfunction

    always_comb begin
        boundary = enable & (~running | (cnt == n_act - CNT_W'(1)));
        n_next   = n_act;
        h_next   = h_act;
        // A load on the boundary edge itself bypasses the shadow.
        if (boundary && load) begin
            n_next = clamp_n(div_value);
            h_next = clamp_h(high_value, clamp_n(div_value));
        end else if (boundary && pending) begin
            n_next = clamp_n(shadow_n);
            h_next = clamp_h(shadow_h, clamp_n(shadow_n));
        end
        if (!enable || boundary)
            next_cnt = '0;
        else
            next_cnt = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            running     <= 1'b0;
            n_act       <= CNT_W'(DEFAULT_DIV);
            h_act       <= CNT_W'(DEFAULT_HIGH);
            shadow_n    <= '0;
            shadow_h    <= '0;
            pending     <= 1'b0;
            divided_clk <= 1'b0;
            tick        <= 1'b0;
        end else begin
            cnt         <= next_cnt;
            running     <= enable;
            n_act       <= n_next;
            h_act       <= h_next;
            divided_clk <= enable & (next_cnt < h_next);
            tick        <= boundary;
            if (load) begin
                shadow_n <= div_value;
                shadow_h <= high_value;
            end
            if (boundary)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;
        end
    end

`ifdef PROG_CLKDIV_PERIOD_COUNT_EN
    logic [15:0] pc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pc_q <= '0;
        else if (boundary)
            pc_q <= pc_q + 16'd1;
    end

    assign period_count = pc_q;
`endif

endmodule

// File: tb/tb_prog_clock_divider.sv
// Testbench for prog_clock_divider: directed scenarios followed by random traffic,
// compared cycle by cycle against a period/position reference model.
module tb_prog_clock_divider;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         load;
    logic [W-1:0] div_value;
    logic [W-1:0] high_value;
    logic         divided_clk;
    logic         tick;
    logic         pending;
`ifdef PROG_CLKDIV_PERIOD_COUNT_EN
    logic [15:0]  period_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: position within the current period and the active/shadow values
    int m_run, m_pos, m_n, m_h, m_sh_n, m_sh_h, m_pend, m_pc, m_tick, m_clk;

    always #5 clk = ~clk;

    prog_clock_divider #(.CNT_W(W), .DEFAULT_DIV(20), .DEFAULT_HIGH(10)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .load        (load),
        .div_value   (div_value),
        .high_value  (high_value),
        .divided_clk (divided_clk),
        .tick        (tick),
`ifdef PROG_CLKDIV_PERIOD_COUNT_EN
        .pending     (pending),
        .period_count(period_count)
`else
        .pending     (pending)
`endif
    );

    function automatic int eff_n(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    function automatic int eff_h(input int h, input int n);
        return (h > n) ? n : h;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_n = 20; m_h = 10;
        m_sh_n = 0; m_sh_h = 0; m_pend = 0; m_pc = 0; m_tick = 0; m_clk = 0;
    endtask

    task automatic model_edge();
        int bnd;
        if (!enable) begin
            m_run = 0; m_pos = 0; m_tick = 0; m_clk = 0;
            if (load) begin m_sh_n = div_value; m_sh_h = high_value; m_pend = 1; end
        end else begin
            bnd = (!m_run || m_pos == m_n - 1) ? 1 : 0;
            if (bnd) begin
                if (load) begin
                    m_n = eff_n(div_value); m_h = eff_h(high_value, m_n);
                end else if (m_pend) begin
                    m_n = eff_n(m_sh_n); m_h = eff_h(m_sh_h, m_n);
                end
                m_pend = 0; m_pos = 0; m_run = 1;
                m_pc = (m_pc + 1) % 65536;
            end else begin
                m_pos++;
                if (load) begin m_sh_n = div_value; m_sh_h = high_value; m_pend = 1; end
            end
            m_tick = bnd;
            m_clk  = (m_pos < m_h) ? 1 : 0;
        end
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".tick"}, int'(tick), m_tick);
        chk({ctx, ".divided_clk"}, int'(divided_clk), m_clk);
        chk({ctx, ".pending"}, int'(pending), m_pend);
`ifdef PROG_CLKDIV_PERIOD_COUNT_EN
        chk({ctx, ".period_count"}, int'(period_count), m_pc);
`endif
    endtask

    task automatic step(input string ctx, input logic en, input logic ld, input int dv, input int hv);
        enable     = en;
        load       = ld;
        div_value  = dv[W-1:0];
        high_value = hv[W-1:0];
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(ctx);
        load = 1'b0;
    endtask

    task automatic run(input string ctx, input int n);
        for (int i = 0; i < n; i++) step(ctx, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic run_to_pos(input string ctx, input int p);
        for (int i = 0; i < 70 && m_pos != p; i++) step(ctx, 1'b1, 1'b0, 0, 0);
        chk({ctx, ".reached_pos"}, m_pos, p);
    endtask

    initial begin
        int ticks;
        model_reset();
        reset_n = 1'b0; enable = 1'b0; load = 1'b0; div_value = '0; high_value = '0;
        #12;
        check_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // defaults: first tick one edge after enable, then 20-clock periods of 10 high
        step("start", 1'b1, 1'b0, 0, 0);
        chk("start.first_tick", int'(tick), 1);
        chk("start.first_high", int'(divided_clk), 1);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            step("defaults", 1'b1, 1'b0, 0, 0);
            ticks += int'(tick);
        end
        chk("defaults.ticks_in_40", ticks, 2);

        run_to_pos("midload", 7);
        step("midload", 1'b1, 1'b1, 5, 2);
        chk("midload.pending_set", int'(pending), 1);
        run("midload", 30);

        step("clamp_hi", 1'b1, 1'b1, 1, 9);
        run("clamp_hi", 12);
        step("clamp_lo", 1'b1, 1'b1, 1, 0);
        run("clamp_lo", 12);

        run_to_pos("wrapload", m_n - 1);
        step("wrapload", 1'b1, 1'b1, 8, 3);
        chk("wrapload.pending_clear", int'(pending), 0);
        run("wrapload", 20);
        run_to_pos("wrapload2", 7);
        step("wrapload2", 1'b1, 1'b1, 6, 4);
        run("wrapload2", 14);

        run_to_pos("abort", 4);
        step("abort", 1'b0, 1'b0, 0, 0);
        chk("abort.clk_low", int'(divided_clk), 0);
        step("idle", 1'b0, 1'b0, 0, 0);
        step("idle_load", 1'b0, 1'b1, 7, 3);
        step("idle", 1'b0, 1'b0, 0, 0);
        step("reenable", 1'b1, 1'b0, 0, 0);
        chk("reenable.tick", int'(tick), 1);
        run("reenable", 20);

        run_to_pos("pend_reset", 1);
        step("pend_reset", 1'b1, 1'b1, 5, 2);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        #2;
        reset_n = 1'b1;
        run("after_reset", 60);

        for (int i = 0; i < 1500; i++) begin
            step("random", ($urandom_range(0, 99) < 95) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
